// File: rtl/ptp_b.sv
// Word-to-byte serialiser: loads one WORD_WIDTH word and emits it MSB-first
// as NUM_BYTES bytes over a valid/ready handshake.
module ptp_b #(
  parameter  int unsigned WORD_WIDTH = 32,
  parameter  int unsigned BYTE_WIDTH = 8,
  localparam int unsigned NUM_BYTES  = WORD_WIDTH / BYTE_WIDTH,
  localparam int unsigned IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] value_i,
  input  logic                  ready_i,
  output logic [BYTE_WIDTH-1:0] value_o,
  output logic                  valid_o,
  output logic [IDX_W-1:0]      index_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t                state, state_n;
  logic [WORD_WIDTH-1:0] shreg, shreg_n;
  logic [IDX_W-1:0]      index, index_n;
  logic                  done, done_n;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
      shreg <= '0;
      index <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      index <= index_n;
      done  <= done_n;
    end
  end

  // The final handshake also shifts, so the register is drained to zero in IDLE.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    index_n = index;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_i) begin
          shreg_n = value_i;
          index_n = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          shreg_n = shreg << BYTE_WIDTH;
          if (index == LAST_IDX) begin
            index_n = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            index_n = index + IDX_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign value_o = shreg[WORD_WIDTH-1 -: BYTE_WIDTH];
  assign valid_o = (state == SEND);
  assign busy_o  = (state == SEND);
  assign index_o = index;
  assign done_o  = done;

endmodule

// File: tb/tb_ptp_b.sv
// Bench for ptp_b: vector table, directed corner sequences, loop-back assembly
// and randomized traffic against a byte-queue reference model.
module tb_ptp_b;

  logic        clock_i = 1'b0;
  logic        reset_i, load_i, ready_i;
  logic [31:0] value_i;
  logic [7:0]  value_o;
  logic        valid_o, busy_o, done_o;
  logic [1:0]  index_o;

  ptp_b #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .load_i(load_i), .value_i(value_i),
    .ready_i(ready_i), .value_o(value_o), .valid_o(valid_o), .index_o(index_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: bytes still to be sent for the current word
  logic [7:0]  mq[$];
  int          m_acc = 0;
  bit          m_done = 0;
  logic [31:0] m_word = '0;

  // loop-back assembler and observation state
  logic [31:0] asm_w = '0;
  int          asm_n = 0;
  int          hs_cnt = 0, done_cnt = 0, cyc = 0;
  logic [7:0]  seen[$];
  int          rises[$];
  bit          track_rise = 0, prev_valid = 0;

  typedef struct {
    bit r; bit l; logic [31:0] v; bit rdy;
    bit ev; logic [7:0] eval; logic [1:0] eidx; bit ebusy; bit edone;
  } vec_t;
  vec_t tbl[7];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(bit r, bit l, logic [31:0] v, bit rdy);
    bit         hs;
    logic [7:0] hb;
    reset_i = r; load_i = l; value_i = v; ready_i = rdy;
    hs = valid_o && rdy && !r;
    hb = value_o;
    @(posedge clock_i);
    cyc++;
    m_done = 0;
    if (r) begin
      mq.delete(); m_acc = 0; asm_n = 0;
    end else if (mq.size() == 0) begin
      if (l) begin
        for (int i = 3; i >= 0; i--) mq.push_back(v[i*8 +: 8]);
        m_acc = 0; m_word = v;
      end
    end else if (rdy) begin
      void'(mq.pop_front());
      m_acc++;
      if (mq.size() == 0) begin m_done = 1; m_acc = 0; end
    end
    if (hs) begin
      hs_cnt++;
      seen.push_back(hb);
      asm_w = {asm_w[23:0], hb};
      asm_n++;
      if (asm_n == 4) begin
        check("loopback_word", asm_w, m_word);
        asm_n = 0;
      end
    end
    #1;
    if (done_o) done_cnt++;
    if (track_rise && valid_o && !prev_valid) rises.push_back(cyc);
    prev_valid = valid_o;
    check("valid", 32'(valid_o), 32'(mq.size() > 0));
    check("value", 32'(value_o), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    check("index", 32'(index_o), 32'(m_acc));
    check("busy",  32'(busy_o),  32'(mq.size() > 0));
    check("done",  32'(done_o),  32'(m_done));
  endtask

  initial begin
    reset_i = 1'b1; load_i = 1'b0; ready_i = 1'b0; value_i = '0;

    tbl[0] = '{1, 0, 32'h0,        1, 0, 8'h00, 2'd0, 0, 0};
    tbl[1] = '{0, 1, 32'hDEADBEEF, 1, 1, 8'hDE, 2'd0, 1, 0};
    tbl[2] = '{0, 0, 32'h0,        1, 1, 8'hAD, 2'd1, 1, 0};
    tbl[3] = '{0, 0, 32'h0,        1, 1, 8'hBE, 2'd2, 1, 0};
    tbl[4] = '{0, 0, 32'h0,        1, 1, 8'hEF, 2'd3, 1, 0};
    tbl[5] = '{0, 0, 32'h0,        1, 0, 8'h00, 2'd0, 0, 1};
    tbl[6] = '{0, 0, 32'h0,        1, 0, 8'h00, 2'd0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].v, tbl[i].rdy);
      check("tbl_valid", 32'(valid_o), 32'(tbl[i].ev));
      check("tbl_value", 32'(value_o), 32'(tbl[i].eval));
      check("tbl_index", 32'(index_o), 32'(tbl[i].eidx));
      check("tbl_busy",  32'(busy_o),  32'(tbl[i].ebusy));
      check("tbl_done",  32'(done_o),  32'(tbl[i].edone));
    end

    // stall pattern
    begin
      int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      done_cnt = 0;
      step(0, 1, 32'h12345678, 1);
      hs_cnt = 0;
      for (int i = 0; i < 7; i++) begin
        step(0, 0, 32'h0, pat[i][0]);
        if (i == 1 || i == 2) check("stall_hold_34", 32'(value_o), 32'h34);
        if (i == 4)           check("stall_hold_56", 32'(value_o), 32'h56);
      end
      step(0, 0, 32'h0, 1);
      check("stall_handshakes", hs_cnt, 4);
      check("stall_done_pulses", done_cnt, 1);
    end

    // load_i ignored while busy, including on the final handshake
    seen.delete();
    step(0, 1, 32'hCAFEF00D, 1);
    step(0, 0, 32'h0,        1);
    step(0, 1, 32'hFFFFFFFF, 1);
    step(0, 0, 32'h0,        1);
    step(0, 1, 32'hFFFFFFFF, 1);
    check("cafe_count", seen.size(), 4);
    if (seen.size() == 4) check("cafe_bytes", {seen[0], seen[1], seen[2], seen[3]}, 32'hCAFEF00D);
    step(0, 0, 32'h0, 1);
    check("cafe_no_restart", 32'(valid_o), 32'd0);

    // reset mid-word
    done_cnt = 0;
    step(0, 1, 32'hA5A5A5A5, 1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    check("rst_outputs", {value_o, 5'd0, valid_o, index_o, busy_o, done_o}, 32'h0);
    step(0, 0, 32'h0, 1);
    check("rst_no_done", done_cnt, 0);
    seen.delete();
    step(0, 1, 32'h01020304, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1);
    check("post_rst_count", seen.size(), 4);
    if (seen.size() == 4) check("post_rst_bytes", {seen[0], seen[1], seen[2], seen[3]}, 32'h01020304);

    // back-to-back loop-back with load_i held high
    begin
      logic [31:0] words[3] = '{32'h00000000, 32'hFFFFFFFF, 32'h80000001};
      rises.delete();
      track_rise = 1;
      for (int w = 0; w < 3; w++) begin
        step(0, 1, words[w], 1);
        for (int k = 0; k < 4; k++) step(0, 1, $urandom, 1);
      end
      step(0, 0, 32'h0, 1);
      track_rise = 0;
      check("b2b_rises", rises.size(), 3);
      if (rises.size() == 3) begin
        check("b2b_period_1", rises[1] - rises[0], 5);
        check("b2b_period_2", rises[2] - rises[1], 5);
      end
    end

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
